// File: rtl/roll_pwm_encoder.sv
// Roll-command to servo pulse encoder: one pulse per frame, width sampled at frame boundary.
// Optional ROLL_SLEW_EN limits per-frame width change to SLEW_CYCLES.
module roll_pwm_encoder #(
    parameter int FRAME_CYCLES  = 1300000,
    parameter int CENTER_CYCLES = 97500,
    parameter int STEP_CYCLES   = 3250,
    parameter int MIN_CYCLES    = 65000,
    parameter int MAX_CYCLES    = 130000,
    parameter int SLEW_CYCLES   = 3250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  roll_mag,
    input  logic [1:0]  direction,
    input  logic        arm,
    output logic        pwm_out,
    output logic        frame_start,
    output logic [16:0] pulse_cycles
);

    if (FRAME_CYCLES < 2 || FRAME_CYCLES > 2097151 || MIN_CYCLES > CENTER_CYCLES ||
        CENTER_CYCLES > MAX_CYCLES || MAX_CYCLES >= FRAME_CYCLES || SLEW_CYCLES < 0) begin : g_param_check
        $error("roll_pwm_encoder: illegal parameter set");
    end

    localparam logic [20:0]        FC_LAST  = 21'(FRAME_CYCLES - 1);
    localparam logic signed [21:0] CENTER_S = 22'(CENTER_CYCLES);
    localparam logic signed [21:0] STEP_S   = 22'(STEP_CYCLES);
    localparam logic signed [21:0] MIN_S    = 22'(MIN_CYCLES);
    localparam logic signed [21:0] MAX_S    = 22'(MAX_CYCLES);

    logic [20:0]        fc;
    logic signed [21:0] mag_s;
    logic signed [21:0] offset;
    logic signed [21:0] tgt_raw;
    logic signed [21:0] tgt;
    logic [16:0]        next_pulse;

    assign mag_s  = $signed(22'(roll_mag));
    assign offset = mag_s * STEP_S;

    // Signed 22-bit math so CENTER - 15*STEP cannot wrap before the clamp.
    always_comb begin
        tgt_raw = CENTER_S;
        if (arm && roll_mag != 4'd0) begin
            case (direction)
                2'b01:   tgt_raw = CENTER_S + offset;
                2'b10:   tgt_raw = CENTER_S - offset;
                default: tgt_raw = CENTER_S;
            endcase
        end
        if (tgt_raw < MIN_S)      tgt = MIN_S;
        else if (tgt_raw > MAX_S) tgt = MAX_S;
        else                      tgt = tgt_raw;
    end

`ifdef ROLL_SLEW_EN
    localparam logic signed [21:0] SLEW_S = 22'(SLEW_CYCLES);

    logic signed [21:0] cur_s;
    logic signed [21:0] diff;

    assign cur_s = $signed({5'b0, pulse_cycles});
    assign diff  = tgt - cur_s;

    // Disarm snaps straight to neutral; otherwise step toward target without overshoot.
    always_comb begin
        next_pulse = 17'(tgt);
        if (!arm)                next_pulse = 17'(CENTER_CYCLES);
        else if (diff > SLEW_S)  next_pulse = 17'(cur_s + SLEW_S);
        else if (diff < -SLEW_S) next_pulse = 17'(cur_s - SLEW_S);
    end
`else
    assign next_pulse = 17'(tgt);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            fc           <= '0;
            pwm_out      <= 1'b0;
            frame_start  <= 1'b0;
            pulse_cycles <= 17'(CENTER_CYCLES);
        end else begin
            frame_start <= (fc == '0);
            pwm_out     <= (fc < {4'b0, pulse_cycles});
            if (fc == FC_LAST) begin
                fc           <= '0;
                pulse_cycles <= next_pulse;
            end else begin
                fc <= fc + 21'd1;
            end
        end
    end

endmodule

// File: tb/tb_roll_pwm_encoder.sv
// Scoreboard bench for roll_pwm_encoder: stimulus pushes per-frame expected widths, monitor measures frames.
module tb_roll_pwm_encoder;
    localparam int FRAME  = 1000;
    localparam int CENTER = 150;
    localparam int STEP   = 5;
    localparam int MIN_W  = 100;
    localparam int MAX_W  = 200;
    localparam int SLEW   = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  roll_mag = 4'd9;
    logic [1:0]  direction = 2'b00;
    logic        arm = 1'b1;
    logic        pwm_out;
    logic        frame_start;
    logic [16:0] pulse_cycles;

    roll_pwm_encoder #(
        .FRAME_CYCLES(FRAME), .CENTER_CYCLES(CENTER), .STEP_CYCLES(STEP),
        .MIN_CYCLES(MIN_W), .MAX_CYCLES(MAX_W), .SLEW_CYCLES(SLEW)
    ) dut (
        .clock(clock), .reset(reset), .roll_mag(roll_mag), .direction(direction),
        .arm(arm), .pwm_out(pwm_out), .frame_start(frame_start), .pulse_cycles(pulse_cycles)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int model_w = CENTER;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Width the servo channel should carry for a given command, before any slew.
    function automatic int ref_target(input bit a, input bit [1:0] d, input int m);
        int t;
        t = CENTER;
        if (a && m != 0) begin
            if (d == 2'b01)      t = CENTER + m * STEP;
            else if (d == 2'b10) t = CENTER - m * STEP;
        end
        if (t < MIN_W) t = MIN_W;
        if (t > MAX_W) t = MAX_W;
        return t;
    endfunction

    // Monitor: each frame_start pops one expected width and measures the pulse.
    bit measuring = 0;
    bit have_prev = 0;
    int width = 0;
    int cur_exp = 0;
    int since = 0;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            measuring = 0;
            have_prev = 0;
            since = 0;
        end else begin
            since++;
            if (frame_start) begin
                if (have_prev) chk("frame_period", since, FRAME);
                have_prev = 1;
                since = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    cur_exp = -1;
                    $display("FAIL frame_unexpected: got a frame_start, expected none queued (t=%0t)", $time);
                end else begin
                    cur_exp = exp_q.pop_front();
                    chk("pulse_cycles", int'(pulse_cycles), cur_exp);
                end
                chk("pwm_at_frame_start", int'(pwm_out), 1);
                measuring = 1;
                width = 0;
            end
            if (measuring) begin
                if (pwm_out) width++;
                else begin
                    chk("pwm_width", width, cur_exp);
                    measuring = 0;
                end
            end else begin
                chk("pwm_outside_pulse", int'(pwm_out), 0);
            end
        end
    end

    task automatic wait_fs();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clock);
            if (frame_start) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_timeout: got no frame_start, expected one within %0d cycles", 2 * FRAME);
        end
    endtask

    // Called inside a frame: wiggle inputs, settle on the command, queue next frame's width.
    task automatic issue(input bit a, input bit [1:0] d, input bit [3:0] m);
        int w;
        repeat ($urandom_range(1, 300)) @(negedge clock);
        arm = 1'($urandom);
        direction = 2'($urandom);
        roll_mag = 4'($urandom);
        repeat ($urandom_range(1, 400)) @(negedge clock);
        arm = a;
        direction = d;
        roll_mag = m;
        w = ref_target(a, d, int'(m));
`ifdef ROLL_SLEW_EN
        if (a) begin
            if (w > model_w + SLEW)      w = model_w + SLEW;
            else if (w < model_w - SLEW) w = model_w - SLEW;
        end
`endif
        model_w = w;
        exp_q.push_back(w);
        wait_fs();
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        exp_q.push_back(CENTER);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            chk("reset_pwm", int'(pwm_out), 0);
            chk("reset_frame_start", int'(frame_start), 0);
            chk("reset_pulse_cycles", int'(pulse_cycles), CENTER);
        end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("frame_start_after_release", int'(frame_start), 1);

        issue(1, 2'b00, 4'd9);
        issue(1, 2'b01, 4'd7);
        issue(1, 2'b10, 4'd15);
        issue(1, 2'b01, 4'd15);
        issue(1, 2'b01, 4'd7);
        issue(0, 2'b01, 4'd4);
        issue(1, 2'b11, 4'd12);
        issue(1, 2'b01, 4'd7);
`ifdef ROLL_SLEW_EN
        issue(1, 2'b01, 4'd7);
        issue(1, 2'b01, 4'd7);
        issue(1, 2'b01, 4'd7);
        issue(1, 2'b01, 4'd7);
`endif

        // Reset in the middle of a wide pulse.
        repeat (50) @(negedge clock);
        chk("pwm_before_reset", int'(pwm_out), 1);
        chk("pulse_before_reset", int'(pulse_cycles), 185);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("midreset_pwm", int'(pwm_out), 0);
            chk("midreset_frame_start", int'(frame_start), 0);
            chk("midreset_pulse_cycles", int'(pulse_cycles), CENTER);
        end
        exp_q.delete();
        model_w = CENTER;
        exp_q.push_back(CENTER);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("frame_start_after_midreset", int'(frame_start), 1);

        repeat (6) issue(1, 2'b01, 4'd10);
        issue(0, 2'b01, 4'd10);

        repeat (20) issue(1'($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom));

        for (int i = 0; i < 2 * FRAME && measuring; i++) @(negedge clock);
        if (measuring) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got pulse still open, expected it closed");
        end
        summary();
        $finish;
    end

    initial begin
        #900000;
        n_err++;
        $display("FAIL watchdog: got time limit reached, expected run complete");
        summary();
        $finish;
    end

endmodule

// File: doc/roll_pwm_encoder.md
Name: roll_pwm_encoder

Overview:
Downstream consumer of the Roll stage. Converts the roll command (roll_mag, direction) into a servo-style roll-channel pulse for the drone's RC transmitter input: one pulse per fixed frame, width centred at neutral and offset by magnitude. The command is sampled once per frame, so the pulse width never changes mid-pulse. An arm input forces neutral.

Parameters:
FRAME_CYCLES, 1300000, clocks per output frame (20 ms at 65 MHz); legal range 2..2097151
CENTER_CYCLES, 97500, neutral pulse width in clocks (1.5 ms)
STEP_CYCLES, 3250, pulse-width change per roll_mag unit (50 us)
MIN_CYCLES, 65000, lower clamp on pulse width (1.0 ms)
MAX_CYCLES, 130000, upper clamp on pulse width (2.0 ms); must satisfy MIN_CYCLES <= CENTER_CYCLES <= MAX_CYCLES < FRAME_CYCLES
SLEW_CYCLES, 3250, max pulse-width change per frame (only used with ROLL_SLEW_EN)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
roll_mag  input  4  roll magnitude 0..15 from Roll
direction  input  2  from Roll: 2'b00 level, 2'b01 right, 2'b10 left, 2'b11 invalid
arm  input  1  1 = follow command, 0 = force neutral
pwm_out  output  1  roll-channel pulse, registered
frame_start  output  1  one-cycle strobe at the start of each frame, registered
pulse_cycles  output  17  pulse width in clocks for the current frame

Behaviour:
- One clock, synchronous active-high reset. The reset value of every register applies at the first edge with reset=1.
- Reset values: pwm_out=0, frame_start=0, pulse_cycles=CENTER_CYCLES, internal frame counter fc=0.
- fc counts 0..FRAME_CYCLES-1 and wraps to 0. Width is 21 bits.
- Registered outputs: frame_start <= (fc==0) and pwm_out <= (fc < pulse_cycles).
- Cycle 0 is the first edge with reset low. frame_start and pwm_out first go high at cycle 1.
- In each frame, pwm_out is high for exactly pulse_cycles consecutive clocks, starting in the frame_start cycle. frame_start recurs every FRAME_CYCLES clocks.
- Sampling: roll_mag, direction and arm are sampled only on the edge where fc==FRAME_CYCLES-1. pulse_cycles updates on that same edge.
- Input changes at any other time have no effect until the next frame boundary, and the pulse in progress is never altered.
- Target computation: signed, 22 bits wide, so there is no underflow.
  - arm=0 -> CENTER.
  - dir=01 -> CENTER + mag*STEP.
  - dir=10 -> CENTER - mag*STEP.
  - dir=00 or 11 -> CENTER.
  - mag=0 -> CENTER regardless of direction.
  - The result is clamped to [MIN_CYCLES, MAX_CYCLES].
- Without slew, pulse_cycles <= target.
- Reset mid-frame or mid-pulse: pwm_out=0 on the reset edge, pulse_cycles returns to CENTER, fc returns to 0, and the frame restarts at cycle 1 after release.
- Reset held for multiple cycles: outputs stay at reset values throughout.

Optional Feature:
Macro ROLL_SLEW_EN.
- Defined: at each frame boundary, pulse_cycles moves toward target by min(|target - pulse_cycles|, SLEW_CYCLES). Target is reached exactly, with no overshoot.
  - arm=0 and reset both bypass slew and snap pulse_cycles to CENTER immediately.
- Undefined: pulse_cycles <= target at each boundary. SLEW_CYCLES is unused.

Test Plan:
All scenarios use bench parameters FRAME=1000, CENTER=150, STEP=5, MIN=100, MAX=200, SLEW=10.
1. Reset for 3 cycles, then release; arm=1, dir=00, mag=9 -> frame_start at cycle 1, 1001, 2001; pwm_out high 150 clocks each frame; pulse_cycles=150.
2. Frame running at 150; at fc=400 set dir=01, mag=7 -> current pulse ends at 150 clocks; next frame pwm_out high 185 clocks; pulse_cycles=185 from the boundary edge.
3. dir=10, mag=15 -> next frame 100 (clamped from 75); then dir=01, mag=15 -> 200 (clamped from 225).
4. Pulse at 185, then arm=0 with dir=01, mag=4 -> next frame 150. Then arm=1, dir=11, mag=12 -> 150.
5. Pulse at 185; assert reset at fc=50 (pwm_out high) -> pwm_out=0 on that edge, pulse_cycles=150. After release, frame_start at cycle 1 and pulse width 150.
6. With ROLL_SLEW_EN, from 150 set dir=01, mag=10 (target 200) -> successive frames 160, 170, 180, 190, 200, 200. Then arm=0 -> next frame 150. Without the macro, the same first step gives 200 in one frame.
